// File: rtl/rails_scheduler.sv
// rails_scheduler: emits the push/pop stream that realises a required departure order through one station stack
// Ports: clk/reset (sync, active-high); number = car count N; data = departure order, one id per cycle;
// op_valid/op/op_car = one operation per cycle (op 1 = push, 0 = pop); done/result = end-of-job pulse and feasibility.
module rails_scheduler #(
    parameter int MAX_N = 10,
    parameter int DEPTH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] number,
    input  logic [3:0] data,
    output logic       op_valid,
    output logic       op,
    output logic [3:0] op_car,
    output logic       done,
    output logic       result
);
    typedef enum logic [1:0] {LOAD_NUM, LOAD_DATA, RUN, FINISH} state_t;
    localparam logic [3:0] MAX_W = 4'(MAX_N);
    localparam logic [3:0] DEPTH_W = 4'(DEPTH);
    state_t     state_q, state_d;
    logic [3:0] n_q, n_d, idx_q, idx_d, sp_q, sp_d, nxt_q, nxt_d;
    // The stack is sized for the largest job; DEPTH only limits how far it may fill.
    logic [3:0] order_q [MAX_N];
    logic [3:0] order_d [MAX_N];
    logic [3:0] stack_q [MAX_N];
    logic [3:0] stack_d [MAX_N];
    logic       op_valid_q, op_valid_d, op_q, op_d, done_q, done_d, result_q, result_d;
    logic [3:0] op_car_q, op_car_d, top;
    assign top = stack_q[sp_q - 4'd1];
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        sp_d       = sp_q;
        nxt_d      = nxt_q;
        order_d    = order_q;
        stack_d    = stack_q;
        op_valid_d = 1'b0;
        op_d       = 1'b0;
        op_car_d   = 4'd0;
        done_d     = 1'b0;
        result_d   = 1'b0;
        case (state_q)
            LOAD_NUM: begin
                n_d = number;
                if (number == 4'd0 || number > MAX_W) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                order_d[idx_q] = data;
                idx_d   = (idx_q == n_q - 4'd1) ? 4'd0 : idx_q + 4'd1;
                state_d = (idx_q == n_q - 4'd1) ? RUN : LOAD_DATA;
            end
            RUN: begin
                if (idx_q == n_q) begin
                    state_d  = FINISH;
                    done_d   = 1'b1;
                    result_d = 1'b1;
                end else if (sp_q != 4'd0 && top == order_q[idx_q]) begin
                    op_valid_d = 1'b1;
                    op_car_d   = top;
                    sp_d       = sp_q - 4'd1;
                    idx_d      = idx_q + 4'd1;
                end else if (nxt_q <= n_q && sp_q < DEPTH_W) begin
                    op_valid_d     = 1'b1;
                    op_d           = 1'b1;
                    op_car_d       = nxt_q;
                    stack_d[sp_q]  = nxt_q;
                    sp_d           = sp_q + 4'd1;
                    nxt_d          = nxt_q + 4'd1;
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            default: begin
                sp_d    = 4'd0;
                idx_d   = 4'd0;
                nxt_d   = 4'd1;
                state_d = LOAD_NUM;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_NUM;
            n_q        <= 4'd0;
            idx_q      <= 4'd0;
            sp_q       <= 4'd0;
            nxt_q      <= 4'd1;
            order_q    <= '{default: 4'd0};
            stack_q    <= '{default: 4'd0};
            op_valid_q <= 1'b0;
            op_q       <= 1'b0;
            op_car_q   <= 4'd0;
            done_q     <= 1'b0;
            result_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            sp_q       <= sp_d;
            nxt_q      <= nxt_d;
            order_q    <= order_d;
            stack_q    <= stack_d;
            op_valid_q <= op_valid_d;
            op_q       <= op_d;
            op_car_q   <= op_car_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end
    assign op_valid = op_valid_q;
    assign op       = op_q;
    assign op_car   = op_car_q;
    assign done     = done_q;
    assign result   = result_q;
endmodule

// File: tb/tb_rails_scheduler.sv
// tb_rails_scheduler: directed checks of rails_scheduler at DEPTH=10 and DEPTH=2
module tb_rails_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] number1 = 4'd0, data1 = 4'd0, number2 = 4'd0, data2 = 4'd0;
    logic       v1, o1, d1, r1, v2, o2, d2, r2;
    logic [3:0] c1, c2;
    int         total = 0;
    int         bad = 0;
    int         ord [10];

    always #5 clk = ~clk;

    rails_scheduler dut1 (.clk(clk), .reset(reset), .number(number1), .data(data1),
        .op_valid(v1), .op(o1), .op_car(c1), .done(d1), .result(r1));
    rails_scheduler #(.MAX_N(10), .DEPTH(2)) dut2 (.clk(clk), .reset(reset), .number(number2), .data(data2),
        .op_valid(v2), .op(o2), .op_car(c2), .done(d2), .result(r2));

    // expected output vector = {op_valid, op, op_car, done, result}
    function automatic logic [7:0] push(input int c);
        return {2'b11, 4'(c), 2'b00};
    endfunction
    function automatic logic [7:0] pop(input int c);
        return {2'b10, 4'(c), 2'b00};
    endfunction
    function automatic logic [7:0] fin(input logic r);
        return {6'b0, 1'b1, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input int w, input string tag, input logic [7:0] e);
        logic [7:0] o;
        o = (w != 0) ? {v2, o2, c2, d2, r2} : {v1, o1, c1, d1, r1};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk(input int w, input string tag, input logic [7:0] e);
        step();
        chk_now(w, tag, e);
    endtask

    // drives number on the LOAD_NUM edge, then cnt order entries
    task automatic load(input int w, input int n, input int cnt);
        if (w != 0) number2 = 4'(n); else number1 = 4'(n);
        step();
        for (int i = 0; i < cnt; i++) begin
            if (w != 0) data2 = 4'(ord[i]); else data1 = 4'(ord[i]);
            step();
        end
    endtask

    // done cycle, then the return to LOAD_NUM with everything idle
    task automatic finish(input int w, input string tag, input logic r);
        chk(w, tag, fin(r));
        chk(w, {tag, "_idle"}, 8'h00);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        // DEPTH=2: full stack blocks 3,2,1
        ord = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
        load(1, 3, 3);
        chk(1, "d2_p1", push(1));
        chk(1, "d2_p2", push(2));
        finish(1, "d2_full", 1'b0);
        ord = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0};
        load(1, 3, 3);
        chk(1, "d2b_p1", push(1));
        chk(1, "d2b_q1", pop(1));
        chk(1, "d2b_p2", push(2));
        chk(1, "d2b_q2", pop(2));
        chk(1, "d2b_p3", push(3));
        chk(1, "d2b_q3", pop(3));
        finish(1, "d2b_done", 1'b1);
        reset = 1'b1;
        step();
        chk_now(0, "rst1", 8'h00);
        chk_now(1, "rst2", 8'h00);
        reset = 1'b0;
        // full reverse order
        ord = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
        load(0, 3, 3);
        chk(0, "rev_p1", push(1));
        chk(0, "rev_p2", push(2));
        chk(0, "rev_p3", push(3));
        chk(0, "rev_q3", pop(3));
        chk(0, "rev_q2", pop(2));
        chk(0, "rev_q1", pop(1));
        finish(0, "rev_done", 1'b1);
        // infeasible 3,1,2
        ord = '{3, 1, 2, 0, 0, 0, 0, 0, 0, 0};
        load(0, 3, 3);
        chk(0, "inf_p1", push(1));
        chk(0, "inf_p2", push(2));
        chk(0, "inf_p3", push(3));
        chk(0, "inf_q3", pop(3));
        finish(0, "inf_done", 1'b0);
        // illegal counts, then N=1
        load(0, 0, 0);
        chk_now(0, "n0_done", fin(1'b0));
        chk(0, "n0_idle", 8'h00);
        load(0, 12, 0);
        chk_now(0, "n12_done", fin(1'b0));
        chk(0, "n12_idle", 8'h00);
        ord = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load(0, 1, 1);
        chk(0, "n1_p1", push(1));
        chk(0, "n1_q1", pop(1));
        finish(0, "n1_done", 1'b1);
        // reset mid-job
        ord = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        load(0, 5, 5);
        chk(0, "ab_p1", push(1));
        chk(0, "ab_p2", push(2));
        chk(0, "ab_p3", push(3));
        reset = 1'b1;
        chk(0, "ab_rst", 8'h00);
        reset = 1'b0;
        ord = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        load(0, 2, 2);
        chk(0, "fr_p1", push(1));
        chk(0, "fr_p2", push(2));
        chk(0, "fr_q2", pop(2));
        chk(0, "fr_q1", pop(1));
        finish(0, "fr_done", 1'b1);
        // back-to-back job with in-order departures
        ord = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
        load(0, 4, 4);
        for (int i = 1; i <= 4; i++) begin
            chk(0, "bb_push", push(i));
            chk(0, "bb_pop", pop(i));
        end
        finish(0, "bb_done", 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rails_scheduler.md
Name: rails_scheduler

Overview:
- Transmit-side companion to the rails departure-order checker in the rails station subsystem.
- Accepts a car count and a required departure order for a single station stack.
- Emits, one per cycle, the serial push/pop operation stream that realises that order.
- Ends each job with a done pulse and a feasibility flag; the operation stream can drive station-control logic or be replayed into the checker for cross-verification.

Parameters:
- MAX_N, 10, largest legal car count (cars numbered 1..N).
- DEPTH, 10, station stack capacity in cars (1..MAX_N).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- number  input  4  car count N; sampled in LOAD_NUM.
- data  input  4  required departure order, one car id per cycle; sampled in LOAD_DATA.
- op_valid  output  1  high for one cycle per emitted operation.
- op  output  1  1 = push (arrival into station), 0 = pop (departure).
- op_car  output  4  car id pushed or popped; 0 when op_valid = 0.
- done  output  1  one-cycle pulse at job end.
- result  output  1  feasibility flag; valid only while done = 1, otherwise 0.

Behaviour:
Reset and output timing
- Reset is sampled only on a clock edge. All outputs go to 0; state goes to LOAD_NUM; stack pointer sp = 0; order index idx = 0; next arrival nxt = 1.
- Reset asserted mid-job aborts the job: no done pulse, and op_valid = 0 from the next edge.
- All outputs are registered and update on the same edge as the internal stack.

State machine (LOAD_NUM -> LOAD_DATA -> RUN -> FINISH -> LOAD_NUM)
- LOAD_NUM:
  - Latch N = number.
  - If N = 0 or N > MAX_N: go to FINISH with result 0; no data is consumed.
  - Otherwise go to LOAD_DATA.
- LOAD_DATA:
  - Store data into order[idx]; increment idx.
  - After N samples (edges), clear idx to 0 and go to RUN.
- RUN: exactly one action per cycle, evaluated in this priority:
  - a) idx = N: go to FINISH, result = 1; no op this cycle.
  - b) sp > 0 and stack[sp-1] = order[idx]: pop. Emit op = 0 and op_car = top; sp--, idx++.
  - c) nxt <= N and sp < DEPTH: push. Emit op = 1 and op_car = nxt; stack[sp] = nxt; sp++, nxt++.
  - d) Otherwise: go to FINISH, result = 0; no op this cycle.
- FINISH:
  - Drive done = 1 with result for one cycle.
  - Clear sp and idx to 0; set nxt = 1.
  - Return to LOAD_NUM; the following edge samples the next number.

Timing and counting rules
- First op_valid appears the cycle after the last data sample.
- A feasible job emits exactly 2N operations, then done follows one cycle after the last pop.
- op_valid is never high in the same cycle as done.
- Out-of-range or duplicate ids in data are not checked. They cannot match any stack top, so the job ends through rule d with result 0.
- Internal counters are 4 bits wide. nxt may reach N+1 (max 11) without overflow.

Test Plan:
- N=3, order 3,2,1 -> ops push1, push2, push3, pop3, pop2, pop1 on 6 consecutive cycles; next cycle done=1, result=1.
- N=3, order 3,1,2 -> push1, push2, push3, pop3; top 2 ≠ 1 and nxt=4 > N, so the next cycle gives done=1, result=0 (4 ops total).
- DEPTH=2, N=3, order 3,2,1 -> push1, push2; stack full, so the next cycle gives done=1, result=0. With the same order and order 1,2,3 at DEPTH=2: push1, pop1, push2, pop2, push3, pop3, then result=1.
- number=0, then number=12 in successive jobs -> each gives done=1, result=0 one cycle after LOAD_NUM, with no op_valid. Then number=1, data=1 -> push1, pop1, done with result=1.
- Assert reset for 1 cycle after the 3rd op of an N=5 job -> all outputs 0 and no done. A fresh job N=2, order 2,1 then runs push1, push2, pop2, pop1 with result=1.
- Back-to-back jobs: done of job A is followed immediately by LOAD_NUM of job B (N=4, order 1,2,3,4) -> alternating push/pop of 1..4 and result=1, with no stale stack contents.
